// File: rtl/score4_pkg.sv
// score4_pkg: board geometry, cell and FSM encodings, win-check direction table
package score4_pkg;
  localparam int ROWS = 6;
  localparam int COLS = 7;
  typedef enum logic [1:0] {EMPTY = 2'd0, PA = 2'd1, PB = 2'd2} cell_t;
  typedef enum logic [3:0] {CLEAR, IDLE, SCAN_RD, SCAN_CHK, WRITE, CHK_RD, CHK_EVAL, DONE, OVER} state_t;
  // horizontal, vertical, rising diagonal, falling diagonal (row delta, col delta)
  localparam logic signed [1:0] DIR_DR [4] = '{2'sd0, 2'sd1, -2'sd1, 2'sd1};
  localparam logic signed [1:0] DIR_DC [4] = '{2'sd1, 2'sd0, 2'sd1, 2'sd1};
endpackage

// File: rtl/score4_step.sv
// score4_step: next (row, col) one step along a direction/sign, plus an in-board flag
module score4_step
  import score4_pkg::*;
#(
  parameter int ROWS = score4_pkg::ROWS,
  parameter int COLS = score4_pkg::COLS
) (
  input  logic [2:0] i_row,
  input  logic [2:0] i_col,
  input  logic [1:0] i_dir,
  input  logic       i_neg,
  output logic [2:0] o_row,
  output logic [2:0] o_col,
  output logic       o_in
);
  logic signed [1:0] w_dr, w_dc;
  logic signed [4:0] w_r, w_c;
  always_comb begin
    w_dr = i_neg ? -DIR_DR[i_dir] : DIR_DR[i_dir];
    w_dc = i_neg ? -DIR_DC[i_dir] : DIR_DC[i_dir];
    w_r = $signed({2'b00, i_row}) + $signed({{3{w_dr[1]}}, w_dr});
    w_c = $signed({2'b00, i_col}) + $signed({{3{w_dc[1]}}, w_dc});
    o_row = w_r[2:0];
    o_col = w_c[2:0];
    o_in = !w_r[4] && (w_r[3:0] < 4'(ROWS)) && !w_c[4] && (w_c[3:0] < 4'(COLS));
  end
endmodule

// File: rtl/score4_move_ctrl.sv
// score4_move_ctrl: connect-four move controller driving an external board memory
module score4_move_ctrl
  import score4_pkg::*;
#(
  parameter int ROWS = score4_pkg::ROWS,
  parameter int COLS = score4_pkg::COLS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [2:0] cmd_col,
  output logic       cmd_ready,
  output logic       rd_en,
  output logic [2:0] rd_row,
  output logic [2:0] rd_col,
  input  logic [1:0] rd_data,
  output logic       wr_en,
  output logic [2:0] wr_row,
  output logic [2:0] wr_col,
  output logic [1:0] wr_data,
  output logic       player,
  output logic       busy,
  output logic       done,
  output logic       invalid_move,
  output logic       win_a,
  output logic       win_b,
  output logic       full_panel
);
  localparam int CELLS = ROWS * COLS;
  localparam int CW = $clog2(CELLS + 1);
  state_t r_state, w_state;
  logic [2:0] r_row, w_row, r_col, w_col, r_cr, w_cr, r_cc, w_cc, w_nr, w_nc;
  logic [1:0] r_dir, w_dir, r_run, w_run;
  logic r_neg, w_neg, r_player, w_player, r_inv, w_inv;
  logic r_wa, w_wa, r_wb, w_wb, r_full, w_full, w_in, w_side;
  logic [CW-1:0] r_cnt, w_cnt;
  cell_t w_pc;

  score4_step #(.ROWS(ROWS), .COLS(COLS)) u_step (
    .i_row(r_cr), .i_col(r_cc), .i_dir(r_dir), .i_neg(r_neg),
    .o_row(w_nr), .o_col(w_nc), .o_in(w_in)
  );

  assign player = r_player;
  assign win_a = r_wa;
  assign win_b = r_wb;
  assign full_panel = r_full;
  assign cmd_ready = (r_state == IDLE) || (r_state == OVER);
  assign busy = !cmd_ready;
  assign w_pc = r_player ? PB : PA;

  always_comb begin
    {w_state, w_row, w_col, w_cr, w_cc} = {r_state, r_row, r_col, r_cr, r_cc};
    {w_dir, w_run, w_neg, w_player, w_inv} = {r_dir, r_run, r_neg, r_player, r_inv};
    {w_wa, w_wb, w_full, w_cnt} = {r_wa, r_wb, r_full, r_cnt};
    {rd_en, rd_row, rd_col, wr_en, wr_row, wr_col, wr_data} = '0;
    {done, invalid_move, w_side} = '0;
    case (r_state)
      CLEAR: begin
        wr_en = !rst;
        wr_row = r_row;
        wr_col = r_col;
        w_col = (r_col == 3'(COLS-1)) ? 3'd0 : r_col + 3'd1;
        w_row = (r_col == 3'(COLS-1)) ? r_row + 3'd1 : r_row;
        w_state = (r_col == 3'(COLS-1) && r_row == 3'(ROWS-1)) ? IDLE : CLEAR;
      end
      IDLE, OVER: if (cmd_valid) begin
        w_inv = (r_state == OVER) || (cmd_col >= 3'(COLS));
        w_state = w_inv ? DONE : SCAN_RD;
        w_col = cmd_col;
        w_row = 3'(ROWS-1);
      end
      SCAN_RD: begin
        {rd_en, rd_row, rd_col} = {1'b1, r_row, r_col};
        w_state = SCAN_CHK;
      end
      SCAN_CHK: begin
        w_state = (rd_data == EMPTY) ? WRITE : (r_row != 3'd0) ? SCAN_RD : DONE;
        w_row = (rd_data != EMPTY && r_row != 3'd0) ? r_row - 3'd1 : r_row;
        w_inv = rd_data != EMPTY && r_row == 3'd0;
      end
      WRITE: begin
        {wr_en, wr_row, wr_col, wr_data} = {1'b1, r_row, r_col, w_pc};
        w_cnt = r_cnt + CW'(1);
        {w_dir, w_neg, w_run, w_cr, w_cc} = {2'd0, 1'b0, 2'd1, r_row, r_col};
        w_state = CHK_RD;
      end
      CHK_RD: if (w_in) begin
        {rd_en, rd_row, rd_col} = {1'b1, w_nr, w_nc};
        {w_cr, w_cc} = {w_nr, w_nc};
        w_state = CHK_EVAL;
      end else w_side = 1'b1;
      // a third match on one side already makes a run of four, so no per-side step limit is kept
      CHK_EVAL: if (rd_data != w_pc) w_side = 1'b1;
      else if (r_run == 2'd3) begin
        w_wa = !r_player;
        w_wb = r_player;
        w_full = r_cnt == CW'(CELLS);
        w_state = DONE;
      end else begin
        w_run = r_run + 2'd1;
        w_state = CHK_RD;
      end
      DONE: begin
        done = 1'b1;
        invalid_move = r_inv;
        w_state = (r_wa || r_wb || r_full) ? OVER : IDLE;
        w_player = r_player ^ !(r_inv || r_wa || r_wb || r_full);
      end
      default: w_state = CLEAR;
    endcase
    if (w_side) begin
      {w_cr, w_cc, w_neg, w_state} = {r_row, r_col, !r_neg, CHK_RD};
      if (r_neg) begin
        w_dir = r_dir + 2'd1;
        w_run = 2'd1;
        w_full = (r_dir == 2'd3) ? (r_cnt == CW'(CELLS)) : r_full;
        w_state = (r_dir == 2'd3) ? DONE : CHK_RD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CLEAR;
      {r_row, r_col, r_cr, r_cc, r_dir, r_run, r_neg} <= '0;
      {r_player, r_inv, r_wa, r_wb, r_full, r_cnt} <= '0;
    end else begin
      r_state <= w_state;
      {r_row, r_col, r_cr, r_cc, r_dir, r_run, r_neg} <= {w_row, w_col, w_cr, w_cc, w_dir, w_run, w_neg};
      {r_player, r_inv, r_wa, r_wb, r_full, r_cnt} <= {w_player, w_inv, w_wa, w_wb, w_full, w_cnt};
    end
  end
endmodule

// File: tb/tb_score4_move_ctrl.sv
// tb_score4_move_ctrl: directed and randomized game checks against a board-level reference model
module tb_score4_move_ctrl;
  logic clk = 1'b0, rst, cmd_valid, cmd_ready, rd_en, wr_en;
  logic [2:0] cmd_col, rd_row, rd_col, wr_row, wr_col;
  logic [1:0] rd_data = 2'd0, wr_data;
  logic player, busy, done, invalid_move, win_a, win_b, full_panel;
  int checks = 0, failures = 0;
  logic [1:0] mem [6][7];
  int wr_total = 0, wr_nz = 0, rd_total = 0, oob = 0;
  int last_wr_row = -1, last_wr_col = -1, last_wr_data = -1;
  int mb [6][7];
  int m_player, m_cnt;
  bit m_wa, m_wb, m_full;
  bit obs_done, obs_inv;
  int lat, obs_wr, obs_rd;

  score4_move_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_col(cmd_col), .cmd_ready(cmd_ready),
    .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .player(player), .busy(busy), .done(done), .invalid_move(invalid_move),
    .win_a(win_a), .win_b(win_b), .full_panel(full_panel)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_en) begin
      wr_total <= wr_total + 1;
      wr_nz <= wr_nz + int'(wr_data != 2'd0);
      last_wr_row <= int'(wr_row);
      last_wr_col <= int'(wr_col);
      last_wr_data <= int'(wr_data);
      if (wr_row < 3'd6 && wr_col < 3'd7) mem[wr_row][wr_col] <= wr_data;
    end
    if (rd_en) begin
      rd_total <= rd_total + 1;
      rd_data <= (rd_row < 3'd6 && rd_col < 3'd7) ? mem[rd_row][rd_col] : 2'd3;
    end
    oob <= oob + int'(wr_en && (wr_row > 3'd5 || wr_col > 3'd6)) + int'(rd_en && (rd_row > 3'd5 || rd_col > 3'd6));
  end

  function automatic int run_len(int r, int c, int dr, int dc, int p);
    int n, rr, cc;
    n = 1;
    for (int s = -1; s <= 1; s += 2)
      for (int k = 1; k <= 3; k++) begin
        rr = r + s * dr * k;
        cc = c + s * dc * k;
        if (rr < 0 || rr > 5 || cc < 0 || cc > 6) break;
        if (mb[rr][cc] != p) break;
        n++;
      end
    return n;
  endfunction

  function automatic bit wins(int r, int c, int p);
    return run_len(r, c, 0, 1, p) >= 4 || run_len(r, c, 1, 0, p) >= 4 ||
           run_len(r, c, 1, 1, p) >= 4 || run_len(r, c, -1, 1, p) >= 4;
  endfunction

  function automatic int drop_row(int c);
    for (int r = 5; r >= 0; r--) if (mb[r][c] == 0) return r;
    return -1;
  endfunction

  task automatic model_reset;
    for (int r = 0; r < 6; r++) for (int c = 0; c < 7; c++) mb[r][c] = 0;
    {m_player, m_cnt, m_wa, m_wb, m_full} = '0;
  endtask

  task automatic model_move(input int c, output bit inv, output int row);
    inv = 1'b1;
    row = -1;
    if (m_wa || m_wb || m_full || c > 6) return;
    row = drop_row(c);
    if (row < 0) return;
    inv = 1'b0;
    mb[row][c] = m_player + 1;
    m_cnt++;
    if (wins(row, c, m_player + 1)) begin
      if (m_player == 1) m_wb = 1'b1;
      else m_wa = 1'b1;
    end
    if (m_cnt == 42) m_full = 1'b1;
    if (!(m_wa || m_wb || m_full)) m_player ^= 1;
  endtask

  task automatic do_reset(output int nclr);
    int w0, n;
    rst = 1'b1;
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    w0 = wr_total;
    rst = 1'b0;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    nclr = wr_total - w0;
  endtask

  task automatic do_move(input int col);
    int n, w0, r0;
    n = 0;
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    w0 = wr_total;
    r0 = rd_total;
    cmd_valid = 1'b1;
    cmd_col = 3'(col);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!done && lat < 70) begin @(negedge clk); lat++; end
    obs_done = done;
    obs_inv = invalid_move;
    obs_wr = wr_total - w0;
    obs_rd = rd_total - r0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    int n, nz0, bad;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_col = 3'd0;
    repeat (2) @(negedge clk);
    checks++;
    if ({cmd_ready, busy, player, done, invalid_move, rd_en, wr_en, win_a, win_b, full_panel} !== 10'b0100000000) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0100000000", {cmd_ready, busy, player, done, invalid_move, rd_en, wr_en, win_a, win_b, full_panel});
    end
    nz0 = wr_nz;
    do_reset(n);
    checks++;
    if (n != 42) begin failures++; $display("FAIL clear_writes got=%0d exp=42", n); end
    checks++;
    if (wr_nz != nz0) begin failures++; $display("FAIL clear_nonzero got=%0d exp=0", wr_nz - nz0); end
    checks++;
    if ({cmd_ready, busy, player} !== 3'b100) begin failures++; $display("FAIL after_clear got=%b exp=100", {cmd_ready, busy, player}); end
    bad = 0;
    for (int r = 0; r < 6; r++) for (int c = 0; c < 7; c++) bad += int'(mem[r][c] !== 2'd0);
    checks++;
    if (bad != 0) begin failures++; $display("FAIL clear_board got=%0d exp=0 dirty cells", bad); end
  endtask

  task automatic test_single;
    int n;
    do_reset(n);
    do_move(3);
    checks++;
    if (!obs_done || lat > 64) begin failures++; $display("FAIL single_done got=%0d lat=%0d exp=1 lat<=64", obs_done, lat); end
    checks++;
    if (obs_inv || obs_wr != 1) begin failures++; $display("FAIL single_write got inv=%0d wr=%0d exp inv=0 wr=1", obs_inv, obs_wr); end
    checks++;
    if (last_wr_row != 5 || last_wr_col != 3 || last_wr_data != 1) begin
      failures++;
      $display("FAIL single_cell got=(%0d,%0d)=%0d exp=(5,3)=1", last_wr_row, last_wr_col, last_wr_data);
    end
    checks++;
    if ({player, win_a, win_b, full_panel} !== 4'b1000) begin failures++; $display("FAIL single_state got=%b exp=1000", {player, win_a, win_b, full_panel}); end
  endtask

  task automatic test_full_col;
    int n;
    do_reset(n);
    repeat (6) do_move(0);
    checks++;
    if (mem[5][0] !== 2'd1 || mem[0][0] !== 2'd2) begin failures++; $display("FAIL fullcol_stack got bottom=%0d top=%0d exp 1,2", mem[5][0], mem[0][0]); end
    do_move(0);
    checks++;
    if (!obs_done || !obs_inv || obs_wr != 0) begin
      failures++;
      $display("FAIL fullcol_reject got done=%0d inv=%0d wr=%0d exp 1,1,0", obs_done, obs_inv, obs_wr);
    end
    checks++;
    if (player !== 1'b0 || win_a || win_b) begin failures++; $display("FAIL fullcol_player got=%0d exp=0", player); end
  endtask

  task automatic test_row_win;
    int n;
    int seq [7] = '{0, 6, 1, 6, 2, 6, 3};
    do_reset(n);
    foreach (seq[i]) do_move(seq[i]);
    checks++;
    if (obs_inv || {win_a, win_b, full_panel, player} !== 4'b1000) begin
      failures++;
      $display("FAIL row_win got inv=%0d wa/wb/full/pl=%b exp 0,1000", obs_inv, {win_a, win_b, full_panel, player});
    end
    checks++;
    if ({cmd_ready, busy} !== 2'b10) begin failures++; $display("FAIL over_ready got=%b exp=10", {cmd_ready, busy}); end
    do_move(4);
    checks++;
    if (!obs_done || !obs_inv || obs_wr != 0 || obs_rd != 0 || lat != 1) begin
      failures++;
      $display("FAIL over_cmd got done=%0d inv=%0d wr=%0d rd=%0d lat=%0d exp 1,1,0,0,1", obs_done, obs_inv, obs_wr, obs_rd, lat);
    end
  endtask

  task automatic test_diag_b;
    int n;
    int seq [10] = '{5, 6, 4, 5, 3, 4, 3, 4, 3, 3};
    do_reset(n);
    foreach (seq[i]) do_move(seq[i]);
    checks++;
    if ({win_a, win_b, full_panel, player} !== 4'b0101) begin
      failures++;
      $display("FAIL diag_win got wa/wb/full/pl=%b exp=0101", {win_a, win_b, full_panel, player});
    end
    checks++;
    if (last_wr_row != 2 || last_wr_col != 3 || last_wr_data != 2) begin
      failures++;
      $display("FAIL diag_cell got=(%0d,%0d)=%0d exp=(2,3)=2", last_wr_row, last_wr_col, last_wr_data);
    end
  endtask

  task automatic test_bad_col;
    int n;
    do_reset(n);
    do_move(7);
    checks++;
    if (!obs_done || !obs_inv || obs_wr != 0 || obs_rd != 0 || lat != 1) begin
      failures++;
      $display("FAIL badcol got done=%0d inv=%0d wr=%0d rd=%0d lat=%0d exp 1,1,0,0,1", obs_done, obs_inv, obs_wr, obs_rd, lat);
    end
    checks++;
    if (player !== 1'b0 || cmd_ready !== 1'b1) begin failures++; $display("FAIL badcol_state got pl=%0d rdy=%0d exp 0,1", player, cmd_ready); end
    do_move(2);
    checks++;
    if (obs_inv || obs_wr != 1 || mem[5][2] !== 2'd1) begin failures++; $display("FAIL badcol_next got inv=%0d wr=%0d exp 0,1", obs_inv, obs_wr); end
  endtask

  task automatic test_ignore;
    int n, w0, dn;
    do_reset(n);
    w0 = wr_total;
    cmd_valid = 1'b1;
    cmd_col = 3'd2;
    @(negedge clk);
    cmd_col = 3'd4;
    checks++;
    if ({cmd_ready, busy} !== 2'b01) begin failures++; $display("FAIL busy_ready got=%b exp=01", {cmd_ready, busy}); end
    n = 0;
    while (!done && n < 70) begin @(negedge clk); n++; end
    cmd_valid = 1'b0;
    dn = 0;
    repeat (5) begin dn += int'(done); @(negedge clk); end
    checks++;
    if (dn != 1 || wr_total - w0 != 1 || mem[5][2] !== 2'd1 || mem[5][4] !== 2'd0) begin
      failures++;
      $display("FAIL ignore got done=%0d wr=%0d c2=%0d c4=%0d exp 1,1,1,0", dn, wr_total - w0, mem[5][2], mem[5][4]);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    do_reset(n);
    do_move(0);
    cmd_valid = 1'b1;
    cmd_col = 3'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!rd_en && n < 10) begin @(negedge clk); n++; end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({cmd_ready, busy, player, done, invalid_move, rd_en, wr_en, win_a, win_b, full_panel} !== 10'b0100000000) begin
      failures++;
      $display("FAIL midreset_outputs got=%b exp=0100000000", {cmd_ready, busy, player, done, invalid_move, rd_en, wr_en, win_a, win_b, full_panel});
    end
    do_reset(n);
    checks++;
    if (n != 42 || player !== 1'b0 || mem[5][0] !== 2'd0) begin
      failures++;
      $display("FAIL midreset_clear got wr=%0d pl=%0d cell=%0d exp 42,0,0", n, player, mem[5][0]);
    end
  endtask

  task automatic pick(input int g, output int c);
    int r;
    c = int'($urandom_range(0, 6));
    if ($urandom_range(0, 15) == 0) begin c = 7; return; end
    if (g == 0) return;
    for (int t = 0; t < 20; t++) begin
      c = int'($urandom_range(0, 6));
      r = drop_row(c);
      if (r >= 0) begin
        mb[r][c] = m_player + 1;
        if (!wins(r, c, m_player + 1)) begin mb[r][c] = 0; return; end
        mb[r][c] = 0;
      end
    end
  endtask

  task automatic test_random;
    int n, c, er, bad;
    bit ei, over;
    for (int g = 0; g < 3; g++) begin
      do_reset(n);
      for (int m = 0; m < 70; m++) begin
        over = m_wa || m_wb || m_full;
        pick(g, c);
        do_move(c);
        model_move(c, ei, er);
        checks++;
        if (!obs_done || lat > 64) begin failures++; $display("FAIL rnd_done g=%0d m=%0d got=%0d lat=%0d exp=1 lat<=64", g, m, obs_done, lat); end
        checks++;
        if (obs_inv !== ei || obs_wr != (ei ? 0 : 1)) begin
          failures++;
          $display("FAIL rnd_move g=%0d m=%0d col=%0d got inv=%0d wr=%0d exp inv=%0d wr=%0d", g, m, c, obs_inv, obs_wr, ei, ei ? 0 : 1);
        end
        checks++;
        if ({player, win_a, win_b, full_panel} !== {m_player[0], m_wa, m_wb, m_full}) begin
          failures++;
          $display("FAIL rnd_state g=%0d m=%0d got=%b exp=%b", g, m, {player, win_a, win_b, full_panel}, {m_player[0], m_wa, m_wb, m_full});
        end
        bad = 0;
        for (int r = 0; r < 6; r++) for (int k = 0; k < 7; k++) bad += int'(mem[r][k] !== 2'(mb[r][k]));
        checks++;
        if (bad != 0) begin failures++; $display("FAIL rnd_board g=%0d m=%0d got=%0d exp=0 differing cells", g, m, bad); end
        if (over) break;
      end
    end
    checks++;
    if (oob != 0) begin failures++; $display("FAIL out_of_board got=%0d exp=0 accesses", oob); end
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_col = 3'd0;
    test_reset();
    test_single();
    test_full_col();
    test_row_win();
    test_diag_b();
    test_bad_col();
    test_ignore();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
